// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : fetch stage, one read outstanding, small instruction buffer
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
   parameter int                   bus_width = 32,
   parameter logic [bus_width-1:0] pc_init   = '0,
   parameter int                   buf_depth = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 i_raddr_valid,
   input  logic                 i_raddr_ready,
   output logic [bus_width-1:0] i_raddr,
   input  logic                 i_rdata_valid,
   output logic                 i_rdata_ready,
   input  logic [bus_width-1:0] i_rdata,
   output logic                 i_waddr_valid,
   output logic [bus_width-1:0] i_waddr,
   output logic                 i_wdata_valid,
   output logic [bus_width-1:0] i_wdata,
   input  logic                 pc_load,
   input  logic [bus_width-1:0] pc_target,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [bus_width-1:0] inst,
   output logic [bus_width-1:0] inst_pc
);

   localparam int PTR_W = (buf_depth > 1) ? $clog2(buf_depth) : 1;
   localparam int CNT_W = $clog2(buf_depth + 1);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(buf_depth);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(buf_depth - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]           state;
   logic [bus_width-1:0] fetch_pc;
   logic [bus_width-1:0] req_pc;
   logic                 drop;

   logic [bus_width-1:0] buf_inst [buf_depth];
   logic [bus_width-1:0] buf_pc   [buf_depth];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic [bus_width-1:0] target_aligned;
   logic                 push;
   logic                 pop;

   assign i_waddr_valid = 1'b0;
   assign i_waddr       = '0;
   assign i_wdata_valid = 1'b0;
   assign i_wdata       = '0;

   assign target_aligned = pc_target & ~bus_width'(3);

   // A redirect outranks both sides of the buffer: no push, no pop that cycle.
   assign push       = i_rdata_ready & i_rdata_valid & ~drop & ~pc_load;
   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready & ~pc_load;
   assign inst       = buf_inst[rd_ptr];
   assign inst_pc    = buf_pc[rd_ptr];

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         fetch_pc      <= pc_init;
         req_pc        <= '0;
         drop          <= 1'b0;
         i_raddr_valid <= 1'b0;
         i_raddr       <= '0;
         i_rdata_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Space was reserved by count, so the eventual push cannot overflow.
               if (pc_load) begin
                  fetch_pc <= target_aligned;
               end else if (count < DEPTH) begin
                  state         <= REQ;
                  i_raddr_valid <= 1'b1;
                  i_raddr       <= fetch_pc;
               end
            end
            REQ: begin
               if (pc_load) begin
                  fetch_pc <= target_aligned;
                  drop     <= 1'b1;
               end
               if (i_raddr_ready) begin
                  req_pc        <= i_raddr;
                  // An address completing after a redirect must not advance the new PC.
                  if (!pc_load && !drop)
                     fetch_pc <= fetch_pc + bus_width'(4);
                  i_raddr_valid <= 1'b0;
                  i_rdata_ready <= 1'b1;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (pc_load)
                  fetch_pc <= target_aligned;
               if (i_rdata_valid) begin
                  drop          <= 1'b0;
                  i_rdata_ready <= 1'b0;
                  state         <= IDLE;
               end else if (pc_load) begin
                  drop <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < buf_depth; i++) begin
            buf_inst[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else if (pc_load) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            buf_inst[wr_ptr] <= i_rdata;
            buf_pc[wr_ptr]   <= req_pc;
            wr_ptr           <= ptr_next(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : randomized bench for instr_fetch against a PC-sequence model
// Revision       : 1.0
// ============================================================================
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_raddr_valid, i_raddr_ready;
   logic [31:0] i_raddr;
   logic        i_rdata_valid, i_rdata_ready;
   logic [31:0] i_rdata;
   logic        i_waddr_valid, i_wdata_valid;
   logic [31:0] i_waddr, i_wdata;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;

   always #5 clk = ~clk;

   instr_fetch #(.bus_width(32), .pc_init(32'h0), .buf_depth(2)) dut (
      .clk(clk), .rst(rst),
      .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
      .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
      .i_waddr_valid(i_waddr_valid), .i_waddr(i_waddr),
      .i_wdata_valid(i_wdata_valid), .i_wdata(i_wdata),
      .pc_load(pc_load), .pc_target(pc_target),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory contents: a bijective scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F5A;
   endfunction

   // stimulus policy
   int          ir_pct, rdy_pct, lat_max, load_pct;
   int          stall_left;
   logic [31:0] stall_addr;
   // memory model
   logic        pend;
   logic [31:0] pend_addr;
   int          lat;
   logic        obs_rhs, obs_dhs;
   logic [31:0] obs_addr;
   // redirect requests
   logic        load_req, trig_en;
   logic [31:0] load_tgt, trig_addr, trig_tgt;
   // reference model and observations
   logic [31:0] exp_pc;
   logic        prev_stall, after_load, want_first;
   logic [31:0] prev_addr, first_pop_pc;
   int          cyc, first_rv, first_iv, hs_cnt, stall_seen, pops;
   logic [31:0] hs_addr [8];
   int          hs_cyc  [8];

   task automatic observe();
      logic rhs, dhs, pop;
      rhs = i_raddr_valid && i_raddr_ready;
      dhs = i_rdata_valid && i_rdata_ready;
      pop = inst_valid && inst_ready;
      cyc++;
      if (prev_stall) begin
         check("raddr_hold_valid", 32'(i_raddr_valid), 32'd1);
         check("raddr_hold_addr", i_raddr, prev_addr);
      end
      prev_stall = i_raddr_valid && !i_raddr_ready;
      prev_addr  = i_raddr;
      if (prev_stall) stall_seen++;
      if (after_load) check("flush_inst_valid", 32'(inst_valid), 32'd0);
      after_load = pc_load;
      if (i_raddr_valid && first_rv < 0) first_rv = cyc;
      if (inst_valid && first_iv < 0) first_iv = cyc;
      obs_rhs  = rhs;
      obs_dhs  = dhs;
      obs_addr = i_raddr;
      if (rhs) begin
         check("one_outstanding", 32'(pend && !dhs), 32'd0);
         check("raddr_aligned", 32'(i_raddr[1:0]), 32'd0);
         if (hs_cnt < 8) begin
            hs_addr[hs_cnt] = i_raddr;
            hs_cyc[hs_cnt]  = cyc;
         end
         hs_cnt++;
         if (trig_en && i_raddr == trig_addr) begin
            trig_en  = 1'b0;
            load_req = 1'b1;
            load_tgt = trig_tgt;
         end
      end
      // Model: decode sees consecutive words from the latest redirect target.
      if (pop && !pc_load) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst_word", inst, mem_word(exp_pc));
         if (want_first) begin
            first_pop_pc = inst_pc;
            want_first   = 1'b0;
         end
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (pc_load) begin
         exp_pc     = pc_target & ~32'h3;
         want_first = 1'b1;
      end
   endtask

   task automatic drive();
      if (obs_dhs) pend = 1'b0;
      if (obs_rhs) begin
         pend      = 1'b1;
         pend_addr = obs_addr;
         lat       = $urandom_range(lat_max, 0);
      end else if (pend && lat > 0) begin
         lat--;
      end
      i_rdata_valid = pend && lat == 0;
      i_rdata       = (pend && lat == 0) ? mem_word(pend_addr) : $urandom;
      if (stall_left > 0 && i_raddr_valid && i_raddr == stall_addr) begin
         i_raddr_ready = 1'b0;
         stall_left--;
      end else begin
         i_raddr_ready = ($urandom_range(99, 0) < rdy_pct);
      end
      inst_ready = ($urandom_range(99, 0) < ir_pct);
      pc_load    = load_req;
      pc_target  = load_tgt;
      load_req   = 1'b0;
      if (!pc_load && load_pct > 0 && $urandom_range(99, 0) < load_pct) begin
         pc_load   = 1'b1;
         pc_target = $urandom_range(1, 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         observe();
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pc_load = 1'b0; pc_target = '0; inst_ready = 1'b0;
      i_raddr_ready = 1'b0; i_rdata_valid = 1'b0; i_rdata = '0;
      pend = 1'b0; lat = 0; load_req = 1'b0; load_tgt = '0;
      obs_rhs = 1'b0; obs_dhs = 1'b0; obs_addr = '0;
      @(negedge clk);
      check("rst_raddr_valid", 32'(i_raddr_valid), 32'd0);
      check("rst_raddr", i_raddr, 32'd0);
      check("rst_rdata_ready", 32'(i_rdata_ready), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_write_side", {i_waddr[15:0] | i_wdata[15:0], 14'd0, i_waddr_valid, i_wdata_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_pc = 32'h0; prev_stall = 1'b0; after_load = 1'b0; want_first = 1'b0;
      prev_addr = '0; first_pop_pc = 32'hDEAD_BEEF;
      cyc = 0; first_rv = -1; first_iv = -1; hs_cnt = 0; stall_seen = 0; pops = 0;
      trig_en = 1'b0; stall_left = 0; stall_addr = '0;
      drive();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ir_pct = 0; rdy_pct = 100; lat_max = 0; load_pct = 0;
      trig_addr = '0; trig_tgt = '0;

      // Decode stalled: two reads fill the buffer, then fetch goes quiet.
      do_reset();
      run(15);
      check("fill_read_count", 32'(hs_cnt), 32'd2);
      check("fill_addr0", hs_addr[0], 32'h0);
      check("fill_addr1", hs_addr[1], 32'h4);
      check("fill_quiet", 32'(i_raddr_valid), 32'd0);
      check("first_latency", 32'(first_iv - first_rv), 32'd2);
      check("issue_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      ir_pct = 100;
      run(20);
      check("resume_addr", hs_addr[2], 32'h8);
      check("resume_pops", 32'(pops > 4), 32'd1);

      // Address channel stalled five cycles on 0x4.
      do_reset();
      stall_addr = 32'h4;
      stall_left = 5;
      run(25);
      check("stall_cycles", 32'(stall_seen), 32'd5);

      // Redirect to 0x103 while waiting for the word at 0x8.
      lat_max = 2;
      do_reset();
      trig_en = 1'b1; trig_addr = 32'h8; trig_tgt = 32'h103;
      run(40);
      check("redirect_fired", 32'(trig_en), 32'd0);
      check("redirect_first_pc", first_pop_pc, 32'h100);

      // Redirect coinciding with a pop from a full buffer.
      ir_pct = 0; lat_max = 0;
      do_reset();
      run(15);
      check("full_before_load", 32'(inst_valid), 32'd1);
      ir_pct = 100;
      load_req = 1'b1; load_tgt = 32'h40;
      run(25);
      check("pop_load_first_pc", first_pop_pc, 32'h40);

      // Redirect near the top of the address space wraps to 0.
      do_reset();
      run(6);
      load_req = 1'b1; load_tgt = 32'hFFFF_FFFE;
      run(30);
      check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);
      check("wrap_continues", 32'(exp_pc < 32'h40 && pops > 3), 32'd1);

      // Randomized traffic with occasional redirects.
      ir_pct = 70; rdy_pct = 70; lat_max = 3; load_pct = 4;
      do_reset();
      run(1500);
      check("random_pops", 32'(pops > 50), 32'd1);
      load_pct = 0;
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
